// File: rtl/iterative_shift_rotate.sv
// ---------------------------------------------------------------------------
// iterative_shift_rotate
//
// Multi-cycle shift/rotate unit. It performs one single-bit step per clock on
// an internal accumulator and uses a start/done handshake with the control
// unit. Rotates and shifts share this one sequential resource.
//
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-high reset; aborts any operation in flight
//   start      request, sampled only while idle
//   mode       000 ROR, 001 ROL, 010 SHR, 011 SHL, 100 SHRA, 101-111 pass
//   data_in    operand, captured on the accepting edge
//   amount     bit count (0..WIDTH-1), captured on the accepting edge
//   result     last completed result, registered
//   carry_out  last bit shifted/rotated out, registered
//   busy       high in every state except idle
//   done       one-cycle completion pulse
// ---------------------------------------------------------------------------
module iterative_shift_rotate #(
  parameter int WIDTH = 32,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] M_ROR  = 3'b000;
  localparam logic [2:0] M_ROL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_SHL  = 3'b011;
  localparam logic [2:0] M_SHRA = 3'b100;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [AMT_W-1:0] cnt;
  logic [2:0]       op;
  logic [WIDTH:0]   stepped;   // {carry, next accumulator}

  // One single-bit step; the MSB of the return value is the bit moved out.
  function automatic logic [WIDTH:0] step_fn(input logic [2:0] m,
                                             input logic [WIDTH-1:0] a);
    logic [WIDTH:0] r;
    case (m)
      M_ROR:   r = {a[0],       a[0],       a[WIDTH-1:1]};
      M_ROL:   r = {a[WIDTH-1], a[WIDTH-2:0], a[WIDTH-1]};
      M_SHR:   r = {a[0],       1'b0,       a[WIDTH-1:1]};
      M_SHL:   r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      M_SHRA:  r = {a[0],       a[WIDTH-1], a[WIDTH-1:1]};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  // Pass-through codes never enter the shift loop.
  function automatic logic is_pass(input logic [2:0] m);
    return m[2] && (m[1:0] != 2'b00);
  endfunction

  assign stepped = step_fn(op, acc);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      op        <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc  <= data_in;
            cnt  <= amount;
            op   <= mode;
            busy <= 1'b1;
            if ((amount == '0) || is_pass(mode)) begin
              // Nothing to shift: complete straight away with the operand.
              state     <= S_DONE;
              result    <= data_in;
              carry_out <= 1'b0;
              done      <= 1'b1;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          acc <= stepped[WIDTH-1:0];
          cnt <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state     <= S_DONE;
            result    <= stepped[WIDTH-1:0];
            carry_out <= stepped[WIDTH];
            done      <= 1'b1;
          end
        end
        S_DONE: begin
          // Any start seen here is dropped, not queued.
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_shift_rotate.sv
module tb_iterative_shift_rotate;

  logic        clk;
  logic        clr;
  logic        start;
  logic [2:0]  mode;
  logic [31:0] data_in;
  logic [4:0]  amount;
  logic [31:0] result;
  logic        carry_out;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  iterative_shift_rotate #(.WIDTH(32), .AMT_W(5)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .mode      (mode),
    .data_in   (data_in),
    .amount    (amount),
    .result    (result),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one operation and watch it for amt+6 cycles. Inputs are driven and
  // outputs sampled on the falling edge. rep1/rep2 are sample indices at which
  // start is re-pulsed with unrelated data (0 = none).
  task automatic run_op(input string tag, input logic [2:0] m, input logic [31:0] d,
                        input logic [4:0] a, input logic [31:0] exp_res,
                        input logic exp_c, input int exp_lat,
                        input int rep1, input int rep2);
    int lat = 0;
    int dn  = 0;
    int bz  = 0;
    @(negedge clk);
    mode = m; data_in = d; amount = a; start = 1'b1;
    for (int i = 1; i <= int'(a) + 6; i++) begin
      @(negedge clk);
      if (busy) bz++;
      if (done) begin
        dn++;
        if (lat == 0) lat = i;
      end
      start = 1'b0;
      if (i == 1) begin
        // Operands change after capture; the operation must not notice.
        data_in = ~d; amount = a ^ 5'h15; mode = m ^ 3'b011;
      end
      if (i == rep1 || i == rep2) begin
        start = 1'b1; data_in = 32'h1234_5678; amount = 5'd1; mode = 3'b011;
      end
    end
    chk({tag, ".result"},  result, exp_res);
    chk({tag, ".carry"},   {31'd0, carry_out}, {31'd0, exp_c});
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".dones"},   dn, 1);
    chk({tag, ".busy"},    bz, exp_lat);
  endtask

  initial begin
    int dn;
    clr = 1'b1; start = 1'b0; mode = 3'b000; data_in = '0; amount = '0;
    #12;
    chk("reset.result", result, 32'h0);
    chk("reset.carry",  {31'd0, carry_out}, 32'd0);
    chk("reset.busy",   {31'd0, busy}, 32'd0);
    chk("reset.done",   {31'd0, done}, 32'd0);
    @(negedge clk);
    clr = 1'b0;

    // 1. ROR by 1
    run_op("ror1",  3'b000, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b1, 2,  0, 0);
    // 2. ROL by 4
    run_op("rol4",  3'b001, 32'h1234_5678, 5'd4,  32'h2345_6781, 1'b1, 5,  0, 0);
    // 3. SHR by 8, SHRA by 31
    run_op("shr8",  3'b010, 32'hA5A5_A5A5, 5'd8,  32'h00A5_A5A5, 1'b1, 9,  0, 0);
    run_op("shra31",3'b100, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 32, 0, 0);
    // 4. amount 0 and pass-through
    run_op("shl0",  3'b011, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1,  0, 0);
    run_op("pass",  3'b111, 32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 1'b0, 1,  0, 0);
    // 5. start re-pulsed during SHIFT and during DONE
    run_op("rol20", 3'b001, 32'h0000_FFFF, 5'd20, 32'hFFF0_000F, 1'b1, 21, 3, 21);

    // 6. async clear mid-operation
    dn = 0;
    @(negedge clk);
    mode = 3'b011; data_in = 32'hFFFF_FFFF; amount = 5'd16; start = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dn++;
    end
    #2 clr = 1'b1;
    #1;
    chk("clr.result", result, 32'h0);
    chk("clr.carry",  {31'd0, carry_out}, 32'd0);
    chk("clr.busy",   {31'd0, busy}, 32'd0);
    chk("clr.done",   {31'd0, done}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("clr.no_done", dn, 0);
    chk("clr.idle_result", result, 32'h0);
    run_op("shr4",  3'b010, 32'hF000_0000, 5'd4,  32'h0F00_0000, 1'b0, 5,  0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iterative_shift_rotate.md
Name: iterative_shift_rotate

Overview:
Multi-cycle, parametrised shift/rotate unit for the datapath ALU. It succeeds the fixed single-bit combinational rotator and performs an operand-selected rotate or shift by a variable amount. It processes one bit position per clock and uses a start/done handshake with the control unit. It produces the result and the last bit shifted out, so rotate and shift instructions can share one sequential resource.

Parameters:
WIDTH, 32, data width in bits; must be a power of two, at least 4.
AMT_W, $clog2(WIDTH), width of the shift-amount field; amount range is 0..WIDTH-1.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
clr  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
mode  input  3  operation select: 000 ROR, 001 ROL, 010 SHR (logical), 011 SHL, 100 SHRA (arithmetic); 101-111 pass-through.
data_in  input  WIDTH  operand, captured on the accepting edge.
amount  input  AMT_W  bit count, captured on the accepting edge.
result  output  WIDTH  last completed result, registered.
carry_out  output  1  last bit shifted or rotated out; registered.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (clr=1, async): state IDLE; result=0, carry_out=0, busy=0, done=0; internal accumulator and counter cleared. Reset during an operation aborts it; no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at the edge: accumulator<=data_in, count<=amount, mode latched.
  - Next state is DONE if amount==0 or mode is pass-through; otherwise SHIFT.
  - start=0: remain in IDLE.
- SHIFT: each edge applies one single-bit step to the accumulator, updates the internal carry bit and decrements count. When count==1, the next state is DONE.
- Step definitions (a = accumulator):
  - ROR: {a[0], a[WIDTH-1:1]}, carry=a[0].
  - ROL: {a[WIDTH-2:0], a[WIDTH-1]}, carry=a[WIDTH-1].
  - SHR: {1'b0, a[WIDTH-1:1]}, carry=a[0].
  - SHL: {a[WIDTH-2:0], 1'b0}, carry=a[WIDTH-1].
  - SHRA: {a[WIDTH-1], a[WIDTH-1:1]}, carry=a[0].
- result and carry_out load on the edge that enters DONE and hold until the next completion.
  - For amount 0 or pass-through: result=data_in, carry_out=0.
- DONE: done=1 for exactly this one cycle; the next edge returns to IDLE unconditionally.
- Latency: with capture at edge t0, done is high in the cycle following edge t_N, where N = amount (N=0 for pass-through).
  - Total: N+1 cycles from the cycle start is presented.
  - Throughput: one operation per N+2 cycles.
- busy is high from the cycle after capture through the DONE cycle inclusive.
- start asserted while busy=1, including during DONE, is ignored and not queued.
- data_in, amount and mode may change freely after capture without affecting the operation in flight.
- Outputs are decoded from registered state/values only; no combinational path from inputs to outputs.

Test Plan:
1. ROR, data_in=0x00000001, amount=1, start pulsed one cycle -> result=0x80000000, carry_out=1; done high exactly once, in the 2nd cycle after the start cycle begins.
2. ROL, data_in=0x12345678, amount=4 -> result=0x23456781, carry_out=1; busy high for 5 cycles; done one cycle wide.
3. SHR, data_in=0xA5A5A5A5, amount=8 -> result=0x00A5A5A5, carry_out=1. Repeat as SHRA with data_in=0x80000000, amount=31 -> result=0xFFFFFFFF, carry_out=0.
4. SHL, data_in=0xDEADBEEF, amount=0 -> result=0xDEADBEEF, carry_out=0, done in the cycle after capture. Repeat with mode=111, amount=5 -> same result and latency.
5. Start a ROL by 20 on 0x0000FFFF, then re-pulse start with different data at cycles 3 and 21 (DONE cycle) -> both ignored; result=0xFFF0000F; exactly one done.
6. Start a SHL by 16 on 0xFFFFFFFF, assert clr asynchronously mid-operation at cycle 7 -> result=0, carry_out=0, busy=0 immediately; no done. A new SHR by 4 on 0xF0000000 afterwards -> result=0x0F000000, carry_out=0.
